// File: rtl/dmem_wait_responder_if.sv
// Data-port bundle between the MIPS core (master) and the wait-state
// data-memory responder (slave).
interface dmem_wait_responder_if #(
   parameter int WIDTH    = 32,
   parameter int ADDRBITS = 14
);
   logic                req;
   logic                we;
   logic [ADDRBITS-1:0] addr;
   logic [WIDTH-1:0]    wdata;
   logic [WIDTH-1:0]    rdata;
   logic                ready;
   logic                stall;
   logic [WIDTH-1:0]    wcount;
   logic                done;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ready, stall, wcount, done
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ready, stall, wcount, done
   );
endinterface

// File: rtl/dmem_wait_responder.sv
// Word-addressed data memory that answers each load/store after LATENCY
// cycles, stalling the core while a request is outstanding. Counts committed
// stores. Optional feature: define DMEM_DONE_DETECT_EN to raise a sticky
// `done` flag on a store of DONE_VALUE to DONE_ADDR; otherwise `done` is 0.
module dmem_wait_responder #(
   parameter int WIDTH      = 32,
   parameter int ADDRBITS   = 14,
   parameter int LATENCY    = 2,
   parameter int DONE_ADDR  = 48,
   parameter int DONE_VALUE = 127
) (
   input  logic clk,
   input  logic rst,
   dmem_wait_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Counter preload; LATENCY=1 never enters WAIT so the value is unused there.
   localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   // Catch illegal parameterisations at elaboration.
   if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
      $error("dmem_wait_responder: LATENCY must be 1..15");
   end
   if ((DONE_ADDR >= (1 << ADDRBITS)) || ($clog2(DONE_VALUE + 1) > WIDTH)) begin : g_bad_done
      $error("dmem_wait_responder: DONE_ADDR/DONE_VALUE do not fit the port widths");
   end

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDRBITS-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]    wdata_q, wdata_d;
   logic [WIDTH-1:0]    wcount_q, wcount_d;
   logic [WIDTH-1:0]    rdata_q;

   // Commit-edge view of the transaction
   logic                commit;
   logic                c_we;
   logic [ADDRBITS-1:0] c_addr;
   logic [WIDTH-1:0]    c_wdata;

   logic [WIDTH-1:0]    mem [0:(1 << ADDRBITS) - 1];

   // Pick the request being committed: with LATENCY=1 the commit is the
   // acceptance edge itself, so the live inputs are used; otherwise the latched copy.
   always_comb begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      commit  = 1'b0;
      if (state_q == IDLE) begin
         c_we    = bus.we;
         c_addr  = bus.addr;
         c_wdata = bus.wdata;
         commit  = (LATENCY == 1) && bus.req;
      end else if (state_q == WAIT) begin
         commit  = (cnt_q == 4'd0);
      end
      // Reset on the commit edge aborts the transaction.
      if (rst) begin
         commit = 1'b0;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wcount_d = wcount_q;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (commit && c_we) begin
         wcount_d = wcount_q + 1'b1;
      end
   end

   // Control and latched-request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wcount_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wcount_q <= wcount_d;
      end
   end

   // Array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (commit && c_we) begin
         mem[c_addr] <= c_wdata;
      end
   end

   // Registered response: store echoes its data, load reads the array.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (commit) begin
         rdata_q <= c_we ? c_wdata : mem[c_addr];
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.ready  = (state_q == RESP);
   assign bus.stall  = bus.req & ~bus.ready;
   assign bus.wcount = wcount_q;

`ifdef DMEM_DONE_DETECT_EN
   logic done_q, done_d;

   // Sticky completion flag, set by the marker store on its commit edge.
   always_comb begin
      done_d = done_q;
      if (commit && c_we && (c_addr == ADDRBITS'(DONE_ADDR)) &&
          (c_wdata == WIDTH'(DONE_VALUE))) begin
         done_d = 1'b1;
      end
   end

   // Completion flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign bus.done = done_q;
`else
   assign bus.done = 1'b0;
`endif

endmodule
